// File: rtl/fifo_unpack_pkg.sv
// ---------------------------------------------------------------------------
// fifo_unpack_pkg
//
// Shared definitions for the FIFO unpack reader and its lane selector.
//
// Contents:
//   idx_width()   - width of the beat index for a given lane count
//                   (clog2, never less than one bit)
//   state_t       - two-state FSM encoding: ST_IDLE (no word held) and
//                   ST_EMIT (word held, beats still to go)
//   BEAT_COUNT_W  - width of the wrapping enqueued-beat counter
//
// Build option: FIFO_UNPACK_MSB_FIRST_EN (see fifo_unpack_lane_mux) changes
// lane order only; nothing in this package depends on it.
// ---------------------------------------------------------------------------
package fifo_unpack_pkg;

  localparam int BEAT_COUNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // A one-bit index is still needed when LANES is 1 or 2, so clamp at 1.
  function automatic int idx_width(input int lanes);
    int w;
    w = $clog2(lanes);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_unpack_lane_mux.sv
// ---------------------------------------------------------------------------
// fifo_unpack_lane_mux
//
// Selects one OUT_WIDTH-wide lane of the held word according to the beat
// index.  The index comes straight from a register in the parent, so the
// output is a plain mux behind a flop and stays stable while the index is
// held (e.g. during downstream back-pressure).
//
// Lane k of the word is hold_word[k*OUT_WIDTH +: OUT_WIDTH].
//   default build                  : beat j emits lane j (LSB lane first)
//   FIFO_UNPACK_MSB_FIRST_EN defined: beat j emits lane LANES-1-j
//
// Ports:
//   hold_word  in   IN_WIDTH   word currently being serialised
//   idx        in   IDX_W      beat number within the word
//   lane_data  out  OUT_WIDTH  selected beat
// ---------------------------------------------------------------------------
module fifo_unpack_lane_mux
  import fifo_unpack_pkg::*;
#(
  parameter  int IN_WIDTH  = 32,
  parameter  int LANES     = 4,
  localparam int OUT_WIDTH = IN_WIDTH / LANES,
  localparam int IDX_W     = idx_width(LANES)
) (
  input  logic [IN_WIDTH-1:0]  hold_word,
  input  logic [IDX_W-1:0]     idx,
  output logic [OUT_WIDTH-1:0] lane_data
);

  // Beat-ordered view of the word: beat_lanes[j] is what beat j carries.
  logic [OUT_WIDTH-1:0] beat_lanes [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      assign beat_lanes[gi] = hold_word[(LANES-1-gi)*OUT_WIDTH +: OUT_WIDTH];
`else
      assign beat_lanes[gi] = hold_word[gi*OUT_WIDTH +: OUT_WIDTH];
`endif
    end
  endgenerate

  assign lane_data = beat_lanes[idx];

endmodule

// File: rtl/fifo_unpack_reader.sv
// ---------------------------------------------------------------------------
// fifo_unpack_reader
//
// Dequeues wide words from an upstream FIFO (S_D / S_EMPTY_N / S_DEQ) and
// enqueues each as LANES narrow beats into a downstream FIFO
// (M_D / M_ENQ / M_FULL_N).  One beat per cycle is sustained: on the last
// beat of a word the next word is dequeued in the same cycle, so there is
// no bubble between words.
//
// Build option: FIFO_UNPACK_MSB_FIRST_EN selects most-significant-lane-first
// ordering (handled inside fifo_unpack_lane_mux).  Handshake and counter
// behaviour do not change with it.
//
// Ports:
//   CLK         in   1          clock
//   RST         in   1          synchronous active-high reset
//   CLR         in   1          synchronous flush, drops any partial word
//   S_D         in   IN_WIDTH   upstream FIFO data out
//   S_EMPTY_N   in   1          upstream FIFO not empty
//   S_DEQ       out  1          upstream dequeue strobe
//   M_D         out  OUT_WIDTH  downstream FIFO data in (valid with M_ENQ)
//   M_ENQ       out  1          downstream enqueue strobe
//   M_FULL_N    in   1          downstream FIFO not full
//   BUSY        out  1          a word is held and not yet fully emitted
//   BEAT_COUNT  out  16         wrapping count of enqueued beats
// ---------------------------------------------------------------------------
module fifo_unpack_reader
  import fifo_unpack_pkg::*;
#(
  parameter  int IN_WIDTH  = 32,
  parameter  int LANES     = 4,
  localparam int OUT_WIDTH = IN_WIDTH / LANES
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLR,
  input  logic [IN_WIDTH-1:0]     S_D,
  input  logic                    S_EMPTY_N,
  output logic                    S_DEQ,
  output logic [OUT_WIDTH-1:0]    M_D,
  output logic                    M_ENQ,
  input  logic                    M_FULL_N,
  output logic                    BUSY,
  output logic [BEAT_COUNT_W-1:0] BEAT_COUNT
);

  localparam int IDX_W = idx_width(LANES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [BEAT_COUNT_W-1:0] count_reg, count_next;
  logic [IN_WIDTH-1:0]     hold_reg;
  logic                    hold_load;

  logic busy;
  logic m_enq;
  logic s_deq;
  logic last;

  // ---------------------------------------------------------------------
  // Handshake strobes.  RST gates them like CLR so that a word sitting in
  // the upstream FIFO during reset is not dequeued and then dropped.
  // ---------------------------------------------------------------------
  assign busy  = (state_reg == ST_EMIT);
  assign m_enq = busy & M_FULL_N & ~CLR & ~RST;
  assign last  = m_enq & (idx_reg == IDX_LAST);
  assign s_deq = S_EMPTY_N & ~CLR & ~RST & (~busy | last);

  // ---------------------------------------------------------------------
  // FSM state, beat index and beat counter
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    hold_load  = 1'b0;

    if (CLR) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      count_next = '0;
    end else begin
      if (m_enq) begin
        count_next = count_reg + 1'b1;
      end

      unique case (state_reg)
        ST_IDLE: begin
          if (s_deq) begin
            state_next = ST_EMIT;
            idx_next   = '0;
            hold_load  = 1'b1;
          end
        end

        ST_EMIT: begin
          if (last) begin
            idx_next = '0;
            if (s_deq) begin
              // Back-to-back: next word replaces the finished one.
              hold_load = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else if (m_enq) begin
            idx_next = idx_reg + 1'b1;
          end
          // Back-pressure (no m_enq): everything holds, M_D stays stable.
        end

        default: begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Hold register is data-path only and carries no reset; its contents
  // are ignored until the first dequeue loads it.
  always_ff @(posedge CLK) begin
    if (hold_load) begin
      hold_reg <= S_D;
    end
  end

  // ---------------------------------------------------------------------
  // Lane selection
  // ---------------------------------------------------------------------
  fifo_unpack_lane_mux #(
    .IN_WIDTH (IN_WIDTH),
    .LANES    (LANES)
  ) u_lane_mux (
    .hold_word (hold_reg),
    .idx       (idx_reg),
    .lane_data (M_D)
  );

  assign S_DEQ      = s_deq;
  assign M_ENQ      = m_enq;
  assign BUSY       = busy;
  assign BEAT_COUNT = count_reg;

  // ---------------------------------------------------------------------
  // Simulation-only sanity checks
  // ---------------------------------------------------------------------
`ifndef SYNTHESIS
  generate
    if (LANES < 2 || (IN_WIDTH % LANES) != 0) begin : g_bad_params
      $error("fifo_unpack_reader: LANES must be >= 2 and divide IN_WIDTH");
    end
  endgenerate

  always @(posedge CLK) begin
    if (!RST) begin
      if (s_deq && !S_EMPTY_N) begin
        $warning("fifo_unpack_reader: S_DEQ asserted while upstream empty");
      end
      if (m_enq && !M_FULL_N) begin
        $warning("fifo_unpack_reader: M_ENQ asserted while downstream full");
      end
    end
  end
`endif

endmodule
